reg_file_param: RTL

Parametrised general-purpose register file for the processor datapath, successor to the fixed 32x32, single-write-port register file. It adds configurable data width and depth, a second write port for dual writeback, optional same-cycle write-to-read bypass, a hardwired zero register, synchronous reset of all contents, and a per-register busy scoreboard that decode uses to detect pending writebacks.

---
 rtl/reg_file_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two read ports, two write ports (port 2 wins on
// a same-address collision), optional write-to-read bypass, hardwired zero register
// and a per-register busy scoreboard for pending writebacks.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] REG_address1,
    input  logic [ADDR_W-1:0] REG_address2,
    output logic [DATA_W-1:0] REG_data_out1,
    output logic [DATA_W-1:0] REG_data_out2,
    output logic              REG_busy1,
    output logic              REG_busy2,
    input  logic              REG_write_1,
    input  logic [ADDR_W-1:0] REG_address_wr,
    input  logic [DATA_W-1:0] REG_data_wb_in1,
    input  logic              REG_write_2,
    input  logic [ADDR_W-1:0] REG_address_wr2,
    input  logic [DATA_W-1:0] REG_data_wb_in2,
    input  logic              REG_claim,
    input  logic [ADDR_W-1:0] REG_address_claim
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic we1_ok, we2_ok, claim_ok;
    logic [DATA_W-1:0] stored1, stored2;
    logic busy_st1, busy_st2;
    logic hit1_1, hit2_1, hit1_2, hit2_2;

    // Out-of-range addresses and the hardwired zero register are never written or claimed.
    function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign we1_ok   = REG_write_1 && valid_addr(REG_address_wr);
    assign we2_ok   = REG_write_2 && valid_addr(REG_address_wr2);
    assign claim_ok = REG_claim   && valid_addr(REG_address_claim);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we2_ok && (REG_address_wr2 == ADDR_W'(i))) begin
                    regs[i] <= REG_data_wb_in2;
                end else if (we1_ok && (REG_address_wr == ADDR_W'(i))) begin
                    regs[i] <= REG_data_wb_in1;
                end

                // A new claim outranks the writeback that retires the previous one.
                if (claim_ok && (REG_address_claim == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if ((we1_ok && (REG_address_wr == ADDR_W'(i))) ||
                             (we2_ok && (REG_address_wr2 == ADDR_W'(i)))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        stored1  = '0;
        stored2  = '0;
        busy_st1 = 1'b0;
        busy_st2 = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                if (REG_address1 == ADDR_W'(i)) begin
                    stored1  = regs[i];
                    busy_st1 = busy[i];
                end
                if (REG_address2 == ADDR_W'(i)) begin
                    stored2  = regs[i];
                    busy_st2 = busy[i];
                end
            end
        end
    end

    assign hit1_1 = (BYPASS != 0) && we1_ok && (REG_address_wr  == REG_address1);
    assign hit2_1 = (BYPASS != 0) && we2_ok && (REG_address_wr2 == REG_address1);
    assign hit1_2 = (BYPASS != 0) && we1_ok && (REG_address_wr  == REG_address2);
    assign hit2_2 = (BYPASS != 0) && we2_ok && (REG_address_wr2 == REG_address2);

    always_comb begin
        REG_data_out1 = stored1;
        REG_data_out2 = stored2;
        if (hit2_1) begin
            REG_data_out1 = REG_data_wb_in2;
        end else if (hit1_1) begin
            REG_data_out1 = REG_data_wb_in1;
        end
        if (hit2_2) begin
            REG_data_out2 = REG_data_wb_in2;
        end else if (hit1_2) begin
            REG_data_out2 = REG_data_wb_in1;
        end
    end

    // Forwarded data is already current, so the pending flag is masked.
    assign REG_busy1 = busy_st1 && !(hit1_1 || hit2_1);
    assign REG_busy2 = busy_st2 && !(hit1_2 || hit2_2);

endmodule
